ir_regfile_sb: RTL and testbench
================================

Name: ir_regfile_sb

Overview:
- Parametrised successor to the 16-bit instruction-register/register-file block.
- Latches the instruction word from memory and decodes the opcode and three register fields.
- Holds an N-entry register file with two combinational read ports and one synchronous write port.
- Adds a per-register pending-write scoreboard that raises a hazard for the control FSM; sits between the memory interface and the ALU datapath.

Parameters:
- DATA_W, 16, instruction and register width.
- NUM_REGS, 16, number of registers (power of 2).
- ADDR_W, 4, register address width = log2(NUM_REGS).
- OPCODE_W, 4, opcode field width; requires OPCODE_W + 3*ADDR_W <= DATA_W.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and claims.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_we  in  1  load IR from mem_data.
- mem_data  in  DATA_W  instruction word from memory.
- claim  in  1  with ir_we, mark the incoming instruction's rd as pending.
- opcode  out  OPCODE_W  IR[DATA_W-1 -: OPCODE_W].
- rs_addr  out  ADDR_W  next field below opcode.
- rt_addr  out  ADDR_W  next field below rs.
- rd_addr  out  ADDR_W  next field below rt.
- ir_q  out  DATA_W  full IR contents.
- rd1_data  out  DATA_W  register[rs_addr].
- rd2_data  out  DATA_W  register[rt_addr].
- wr_en  in  1  register write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- hazard  out  1  rs or rt of current IR has a pending write.
- pending  out  NUM_REGS  scoreboard bit vector, bit i = register i.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: IR=0, all registers=0, pending=0. Outputs follow: opcode, fields, rd1/rd2 = 0, hazard = 0.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- IR:
  - On rising edge with ir_we=1, IR <= mem_data. Otherwise IR holds.
  - Field outputs are combinational slices of IR; 0-cycle latency after the edge.
- Reads: rd1_data/rd2_data are combinational from the register array at rs_addr/rt_addr.
  - With ZERO_REG=1, address 0 always reads 0.
- Write: on rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - Write to address 0 with ZERO_REG=1 is discarded.
  - Read of the same address in the write cycle returns the old value; new value is visible the cycle after.
- Scoreboard:
  - Set: edge with ir_we=1 and claim=1 sets pending[mem_data rd field]; suppressed for rd=0 when ZERO_REG=1.
  - Clear: edge with wr_en=1 clears pending[wr_addr].
  - Same-edge set and clear on the same address: set wins (new producer supersedes the retiring one).
  - Re-claiming an already-pending register: stays 1; no counting.
- hazard = pending[rs_addr] | pending[rt_addr], combinational, from the current IR.
- ir_we and wr_en may be asserted in the same cycle; they are fully independent apart from the scoreboard collision rule above.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - rd1_data returns wr_data in the write cycle when wr_en=1 and wr_addr==rs_addr (not a discarded zero-register write); rd2_data likewise for rt_addr.
  - hazard is masked for a source whose pending write is being retired this cycle (wr_en=1, wr_addr match).
- Undefined: no forwarding; old value and hazard persist until the edge after the write.

Test Plan:
- Reset then release: rst_n=0 for 3 cycles, then 1 -> all outputs 0, pending=16'h0000. Reasserting rst_n between edges clears a loaded IR instantly.
- IR decode: ir_we=1, mem_data=16'h1248 -> opcode=1, rs=2, rt=4, rd=8, ir_q=16'h1248. Next cycle with ir_we=0 and mem_data=16'hFFFF, IR still holds 16'h1248.
- Write/read:
  - wr_en=1, wr_addr=2, wr_data=16'h8888 -> after the edge, with IR=16'h1248, rd1_data=16'h8888.
  - Write 16'hBEEF to reg 0 -> reads 0.
  - Without the macro, the same-cycle read of reg 2 returns the old value.
- Scoreboard:
  - Load 16'h1002 with claim=1 -> pending[2]=1; then load 16'h1248 -> hazard=1.
  - wr_en to reg 2 -> pending[2]=0, hazard=0 next cycle.
- Collision: pending[5]=1; same edge wr_en wr_addr=5 and ir_we+claim with rd=5 -> pending[5] remains 1.
- RF_BYPASS_EN:
  - IR=16'h1248, wr_en=1, wr_addr=4, wr_data=16'h1234 -> rd2_data=16'h1234 in the same cycle.
  - With pending[4]=1, hazard=0 during that cycle.

Source files
------------

// File: rtl/ir_regfile_sb.sv
// ----------------------------------------------------------------------------
// ir_regfile_sb
//   Instruction register, register file and pending-write scoreboard.
//   The instruction word from memory is latched into the IR and sliced into
//   opcode/rs/rt/rd fields. Two combinational read ports are addressed by
//   rs/rt, and one synchronous write port updates the array. A per-register
//   pending bit is set when an instruction claims its rd and cleared when the
//   write to that register retires. The hazard output tells the control FSM
//   that a source of the current instruction is still being produced.
//
// Optional build macro: RF_BYPASS_EN
//   When defined, the read ports forward wr_data in the write cycle and a
//   retiring write masks the hazard for that source in the same cycle.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ir_we     in   load IR from mem_data
//   mem_data  in   instruction word from memory
//   claim     in   with ir_we, mark incoming rd as pending
//   opcode    out  IR top field
//   rs_addr   out  first source register field
//   rt_addr   out  second source register field
//   rd_addr   out  destination register field
//   ir_q      out  full IR contents
//   rd1_data  out  register[rs_addr]
//   rd2_data  out  register[rt_addr]
//   wr_en     in   register write strobe
//   wr_addr   in   write address
//   wr_data   in   write data
//   hazard    out  rs or rt of current IR has a pending write
//   pending   out  scoreboard vector, bit i = register i
// ----------------------------------------------------------------------------
module ir_regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int OPCODE_W = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ir_we,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                claim,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   rs_addr,
    output logic [ADDR_W-1:0]   rt_addr,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   ir_q,
    output logic [DATA_W-1:0]   rd1_data,
    output logic [DATA_W-1:0]   rd2_data,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);

    // Field positions, packed downward from the MSB of the instruction word.
    localparam int RS_MSB = DATA_W - OPCODE_W - 1;
    localparam int RT_MSB = RS_MSB - ADDR_W;
    localparam int RD_MSB = RT_MSB - ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    logic [ADDR_W-1:0]   claim_rd_s;
    logic                wr_commit_s;
    logic                claim_set_s;
    logic [DATA_W-1:0]   rd1_raw_s;
    logic [DATA_W-1:0]   rd2_raw_s;
    logic                src1_pend_s;
    logic                src2_pend_s;

    assign claim_rd_s = mem_data[RD_MSB -: ADDR_W];

    // A write to the hard-wired zero register never reaches the array.
    assign wr_commit_s = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_ZERO));
    assign claim_set_s = ir_we && claim &&
                         !((ZERO_REG != 0) && (claim_rd_s == ADDR_ZERO));

    // Instruction register load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= DATA_ZERO;
        end else if (ir_we) begin
            ir_q <= mem_data;
        end
    end

    // Combinational field decode of the latched instruction.
    always_comb begin
        opcode  = ir_q[DATA_W-1 -: OPCODE_W];
        rs_addr = ir_q[RS_MSB -: ADDR_W];
        rt_addr = ir_q[RT_MSB -: ADDR_W];
        rd_addr = ir_q[RD_MSB -: ADDR_W];
    end

    // Register array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_ZERO;
            end
        end else if (wr_commit_s) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Array read with the zero register forced to zero.
    always_comb begin
        rd1_raw_s = regs_q[rs_addr];
        rd2_raw_s = regs_q[rt_addr];
        if ((ZERO_REG != 0) && (rs_addr == ADDR_ZERO)) begin
            rd1_raw_s = DATA_ZERO;
        end else begin
            rd1_raw_s = regs_q[rs_addr];
        end
        if ((ZERO_REG != 0) && (rt_addr == ADDR_ZERO)) begin
            rd2_raw_s = DATA_ZERO;
        end else begin
            rd2_raw_s = regs_q[rt_addr];
        end
    end

    // Scoreboard next state: clear first, then set, so a new producer wins
    // over the write retiring on the same edge.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (claim_set_s) begin
            pending_d[claim_rd_s] = 1'b1;
        end else begin
            pending_d[claim_rd_s] = pending_d[claim_rd_s];
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

`ifdef RF_BYPASS_EN
    // Read ports forward the committing write; a retiring write hides the
    // hazard of the source it produces.
    always_comb begin
        rd1_data    = rd1_raw_s;
        rd2_data    = rd2_raw_s;
        src1_pend_s = pending_q[rs_addr];
        src2_pend_s = pending_q[rt_addr];
        if (wr_commit_s && (wr_addr == rs_addr)) begin
            rd1_data = wr_data;
        end else begin
            rd1_data = rd1_raw_s;
        end
        if (wr_commit_s && (wr_addr == rt_addr)) begin
            rd2_data = wr_data;
        end else begin
            rd2_data = rd2_raw_s;
        end
        if (wr_en && (wr_addr == rs_addr)) begin
            src1_pend_s = 1'b0;
        end else begin
            src1_pend_s = pending_q[rs_addr];
        end
        if (wr_en && (wr_addr == rt_addr)) begin
            src2_pend_s = 1'b0;
        end else begin
            src2_pend_s = pending_q[rt_addr];
        end
        hazard = src1_pend_s | src2_pend_s;
    end
`else
    // No forwarding: old data and hazard persist until after the write edge.
    always_comb begin
        rd1_data    = rd1_raw_s;
        rd2_data    = rd2_raw_s;
        src1_pend_s = pending_q[rs_addr];
        src2_pend_s = pending_q[rt_addr];
        hazard      = src1_pend_s | src2_pend_s;
    end
`endif

endmodule

// File: tb/tb_ir_regfile_sb.sv
module tb_ir_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        ir_we;
    logic [15:0] mem_data;
    logic        claim;
    logic [3:0]  opcode;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rd_addr;
    logic [15:0] ir_q;
    logic [15:0] rd1_data;
    logic [15:0] rd2_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hazard;
    logic [15:0] pending;

    int checks_r;
    int errors_r;

    ir_regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_we    (ir_we),
        .mem_data (mem_data),
        .claim    (claim),
        .opcode   (opcode),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .ir_q     (ir_q),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hazard   (hazard),
        .pending  (pending)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus.
    initial begin
        checks_r = 0;
        errors_r = 0;
        rst_n    = 1'b0;
        ir_we    = 1'b0;
        mem_data = 16'h0000;
        claim    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 4'h0;
        wr_data  = 16'h0000;

        repeat (3) tick();
        check_eq("rst_ir", 32'(ir_q), 32'h0000);
        check_eq("rst_opcode", 32'(opcode), 32'h0);
        check_eq("rst_rd1", 32'(rd1_data), 32'h0000);
        check_eq("rst_rd2", 32'(rd2_data), 32'h0000);
        check_eq("rst_hazard", 32'(hazard), 32'h0);
        check_eq("rst_pending", 32'(pending), 32'h0000);
        rst_n = 1'b1;

        // IR decode
        ir_we = 1'b1; mem_data = 16'h1248;
        tick();
        check_eq("dec_ir", 32'(ir_q), 32'h1248);
        check_eq("dec_opcode", 32'(opcode), 32'h1);
        check_eq("dec_rs", 32'(rs_addr), 32'h2);
        check_eq("dec_rt", 32'(rt_addr), 32'h4);
        check_eq("dec_rd", 32'(rd_addr), 32'h8);
        ir_we = 1'b0; mem_data = 16'hFFFF;
        tick();
        check_eq("ir_hold", 32'(ir_q), 32'h1248);

        // Write reg 2 and observe same-cycle then next-cycle read
        wr_en = 1'b1; wr_addr = 4'h2; wr_data = 16'h8888;
        #1;
`ifdef RF_BYPASS_EN
        check_eq("wr_same_cycle", 32'(rd1_data), 32'h8888);
`else
        check_eq("wr_same_cycle", 32'(rd1_data), 32'h0000);
`endif
        tick();
        wr_en = 1'b0;
        check_eq("wr_read", 32'(rd1_data), 32'h8888);

        // Zero register ignores writes
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 16'hBEEF;
        ir_we = 1'b1; mem_data = 16'h1000;
        tick();
        wr_en = 1'b0; ir_we = 1'b0;
        check_eq("zero_rd1", 32'(rd1_data), 32'h0000);
        check_eq("zero_rd2", 32'(rd2_data), 32'h0000);

        // Scoreboard set and hazard
        ir_we = 1'b1; claim = 1'b1; mem_data = 16'h1002;
        tick();
        check_eq("sb_set", 32'(pending), 32'h0004);
        check_eq("sb_nohaz", 32'(hazard), 32'h0);
        claim = 1'b0; mem_data = 16'h1248;
        tick();
        ir_we = 1'b0;
        check_eq("sb_hazard", 32'(hazard), 32'h1);

        // Retire reg 2
        wr_en = 1'b1; wr_addr = 4'h2; wr_data = 16'h5555;
        #1;
`ifdef RF_BYPASS_EN
        check_eq("sb_retire_cyc", 32'(hazard), 32'h0);
`else
        check_eq("sb_retire_cyc", 32'(hazard), 32'h1);
`endif
        tick();
        wr_en = 1'b0;
        check_eq("sb_clear", 32'(pending), 32'h0000);
        check_eq("sb_clear_haz", 32'(hazard), 32'h0);
        check_eq("sb_rd1", 32'(rd1_data), 32'h5555);

        // Collision: set wins over clear
        ir_we = 1'b1; claim = 1'b1; mem_data = 16'h0005;
        tick();
        check_eq("col_pre", 32'(pending), 32'h0020);
        mem_data = 16'h1455;
        wr_en = 1'b1; wr_addr = 4'h5; wr_data = 16'h7777;
        tick();
        ir_we = 1'b0; claim = 1'b0; wr_en = 1'b0;
        check_eq("col_pending", 32'(pending), 32'h0020);
        check_eq("col_hazard", 32'(hazard), 32'h1);
        check_eq("col_rd2", 32'(rd2_data), 32'h7777);

        // Claim reg 4, then test same-cycle forwarding on rt
        ir_we = 1'b1; claim = 1'b1; mem_data = 16'h1244;
        tick();
        claim = 1'b0; mem_data = 16'h1248;
        tick();
        ir_we = 1'b0;
        check_eq("byp_pend", 32'(pending), 32'h0030);
        check_eq("byp_haz_pre", 32'(hazard), 32'h1);
        wr_en = 1'b1; wr_addr = 4'h4; wr_data = 16'h1234;
        #1;
`ifdef RF_BYPASS_EN
        check_eq("byp_rd2", 32'(rd2_data), 32'h1234);
        check_eq("byp_hazard", 32'(hazard), 32'h0);
`else
        check_eq("byp_rd2", 32'(rd2_data), 32'h0000);
        check_eq("byp_hazard", 32'(hazard), 32'h1);
`endif
        check_eq("byp_rd1", 32'(rd1_data), 32'h5555);
        tick();
        wr_en = 1'b0;
        check_eq("post_rd2", 32'(rd2_data), 32'h1234);
        check_eq("post_hazard", 32'(hazard), 32'h0);
        check_eq("post_pend", 32'(pending), 32'h0020);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ir", 32'(ir_q), 32'h0000);
        check_eq("arst_pend", 32'(pending), 32'h0000);
        check_eq("arst_rd1", 32'(rd1_data), 32'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
